// File: rtl/denise_sprite_shifter.sv
// Denise sprite channel: bus-written position/control/data latches feeding a
// pair of 16-bit shifters that serialise one sprite line starting at hstart.
module denise_sprite_shifter #(
    parameter int unsigned SPRITE_ID = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    input  logic [8:0]  hpos,
    output logic [1:0]  sprdata,
    output logic        nsprite,
    output logic        attach
);

    localparam logic [8:0] PosAddr  = 9'h140 + 9'(8 * SPRITE_ID);
    localparam logic [8:0] CtlAddr  = PosAddr + 9'd2;
    localparam logic [8:0] DataAddr = PosAddr + 9'd4;
    localparam logic [8:0] DatbAddr = PosAddr + 9'd6;

    logic [8:0]  hstart_q, hstart_d;
    logic [15:0] datla_q, datla_d;
    logic [15:0] datlb_q, datlb_d;
    logic [15:0] shifta_q, shifta_d;
    logic [15:0] shiftb_q, shiftb_d;
    logic        armed_q, armed_d;
    logic        attach_q, attach_d;

    logic pos_wr, ctl_wr, data_wr, datb_wr;
    logic match;

    assign pos_wr  = (reg_address_in == PosAddr[8:1]);
    assign ctl_wr  = (reg_address_in == CtlAddr[8:1]);
    assign data_wr = (reg_address_in == DataAddr[8:1]);
    assign datb_wr = (reg_address_in == DatbAddr[8:1]);

    // Match uses the pre-write register values, so a same-cycle write only
    // affects the next match.
    assign match = armed_q && (hpos == hstart_q);

    always_comb begin
        hstart_d = hstart_q;
        datla_d  = datla_q;
        datlb_d  = datlb_q;
        shifta_d = shifta_q;
        shiftb_d = shiftb_q;
        armed_d  = armed_q;
        attach_d = attach_q;

        if (clk7_en) begin
            if (pos_wr) begin
                hstart_d[8:1] = data_in[7:0];
            end
            if (ctl_wr) begin
                hstart_d[0] = data_in[0];
                attach_d    = data_in[7];
                armed_d     = 1'b0;
            end
            if (data_wr) begin
                datla_d = data_in;
                armed_d = 1'b1;
            end
            if (datb_wr) begin
                datlb_d = data_in;
            end

            if (match) begin
                shifta_d = datla_q;
                shiftb_d = datlb_q;
            end else begin
                shifta_d = {shifta_q[14:0], 1'b0};
                shiftb_d = {shiftb_q[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hstart_q <= '0;
            datla_q  <= '0;
            datlb_q  <= '0;
            shifta_q <= '0;
            shiftb_q <= '0;
            armed_q  <= 1'b0;
            attach_q <= 1'b0;
        end else begin
            hstart_q <= hstart_d;
            datla_q  <= datla_d;
            datlb_q  <= datlb_d;
            shifta_q <= shifta_d;
            shiftb_q <= shiftb_d;
            armed_q  <= armed_d;
            attach_q <= attach_d;
        end
    end

    assign sprdata = {shiftb_q[15], shifta_q[15]};
    assign nsprite = shiftb_q[15] | shifta_q[15];
    assign attach  = attach_q;

endmodule

// File: tb/tb_denise_sprite_shifter.sv
// Directed bench for denise_sprite_shifter (channel 0): register writes,
// hpos sweeps against a bit-select model of the expected pixel stream.
module tb_denise_sprite_shifter;

    localparam logic [8:0] PosA  = 9'h140;
    localparam logic [8:0] CtlA  = 9'h142;
    localparam logic [8:0] DataA = 9'h144;
    localparam logic [8:0] DatbA = 9'h146;
    localparam logic [8:0] IdleA = 9'h1FE;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk7_en;
    logic [8:1]  reg_address_in;
    logic [15:0] data_in;
    logic [8:0]  hpos;
    logic [1:0]  sprdata;
    logic        nsprite;
    logic        attach;

    int n_checks = 0;
    int n_errors = 0;

    denise_sprite_shifter #(
        .SPRITE_ID(0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clk7_en       (clk7_en),
        .reg_address_in(reg_address_in),
        .data_in       (data_in),
        .hpos          (hpos),
        .sprdata       (sprdata),
        .nsprite       (nsprite),
        .attach        (attach)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One 7MHz pixel: enable for one clk, then three idle clks; ends 1ns past an edge.
    task automatic step();
        clk7_en = 1'b1;
        @(posedge clk);
        #1;
        clk7_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [8:0] a);
        logic [8:0] t;
        t = a;
        reg_address_in = t[8:1];
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d);
        hpos = 9'h1FF;
        set_addr(a);
        data_in = d;
        step();
        set_addr(IdleA);
    endtask

    // Pixel k (1..16) after the match at hs is {db[16-k], da[16-k]}; otherwise empty.
    task automatic sweep(input string tag, input logic [8:0] lo, input logic [8:0] hi,
                         input logic [8:0] hs, input logic [15:0] da, input logic [15:0] db);
        logic [1:0] exp;
        int k;
        for (int h = int'(lo); h <= int'(hi); h++) begin
            hpos = 9'(h);
            step();
            k = h - int'(hs) + 1;
            exp = (k >= 1 && k <= 16) ? {db[16-k], da[16-k]} : 2'b00;
            check($sformatf("%s sprdata h=%h", tag, h), {14'd0, sprdata}, {14'd0, exp});
            check($sformatf("%s nsprite h=%h", tag, h), {15'd0, nsprite}, {15'd0, |exp});
        end
    endtask

    initial begin
        reset_n = 1'b1;
        clk7_en = 1'b0;
        data_in = '0;
        hpos    = 9'h1FF;
        set_addr(IdleA);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset sprdata", {14'd0, sprdata}, 16'd0);
        check("reset nsprite", {15'd0, nsprite}, 16'd0);
        check("reset attach", {15'd0, attach}, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Solid A-plane line at hstart 0x080.
        wr(PosA, 16'h0040);
        wr(CtlA, 16'h0000);
        wr(DataA, 16'hFFFF);
        wr(DatbA, 16'h0000);
        check("attach after ctl0", {15'd0, attach}, 16'd0);
        sweep("solid", 9'h070, 9'h0A0, 9'h080, 16'hFFFF, 16'h0000);

        // Edge pixels only; enable low must freeze the shifter.
        wr(DataA, 16'h8001);
        wr(DatbA, 16'h0001);
        hpos = 9'h080;
        step();
        check("edge pix1", {14'd0, sprdata}, 16'd1);
        repeat (8) @(posedge clk);
        #1;
        check("edge hold en0", {14'd0, sprdata}, 16'd1);
        sweep("edge", 9'h081, 9'h092, 9'h080, 16'h8001, 16'h0001);

        // CTL write disarms; DATA re-arms at the new hstart 0x081.
        wr(CtlA, 16'h0081);
        check("ctl attach", {15'd0, attach}, 16'd1);
        sweep("disarmed", 9'h07E, 9'h095, 9'h081, 16'h0000, 16'h0000);
        wr(DataA, 16'hF00F);
        sweep("rearm", 9'h07E, 9'h095, 9'h081, 16'hF00F, 16'h0001);

        // Restart mid-shift: old low byte of 0x00FF must not survive the new match.
        wr(DataA, 16'h00FF);
        wr(DatbA, 16'h0000);
        sweep("old", 9'h081, 9'h088, 9'h081, 16'h00FF, 16'h0000);
        wr(DataA, 16'h8000);
        check("old pix9", {14'd0, sprdata}, 16'd1);
        wr(PosA, 16'h0050);
        check("old pix10", {14'd0, sprdata}, 16'd1);
        sweep("restart", 9'h0A1, 9'h0B5, 9'h0A1, 16'h8000, 16'h0000);

        // DATA write coincident with match loads the old latch.
        wr(DataA, 16'hAAAA);
        hpos = 9'h0A1;
        set_addr(DataA);
        data_in = 16'h5555;
        step();
        set_addr(IdleA);
        check("coinc data pix1", {14'd0, sprdata}, 16'd1);
        sweep("coinc data", 9'h0A2, 9'h0B5, 9'h0A1, 16'hAAAA, 16'h0000);
        sweep("next line", 9'h0A1, 9'h0B5, 9'h0A1, 16'h5555, 16'h0000);

        // CTL write coincident with match: load happens, then disarmed.
        wr(DataA, 16'hFFFF);
        hpos = 9'h0A1;
        set_addr(CtlA);
        data_in = 16'h0081;
        step();
        set_addr(IdleA);
        check("coinc ctl pix1", {14'd0, sprdata}, 16'd1);
        sweep("coinc ctl", 9'h0A2, 9'h0B5, 9'h0A1, 16'hFFFF, 16'h0000);
        check("coinc ctl attach", {15'd0, attach}, 16'd1);
        sweep("after ctl", 9'h0A1, 9'h0B5, 9'h0A1, 16'h0000, 16'h0000);

        // Asynchronous reset mid-shift.
        wr(DataA, 16'hFFFF);
        sweep("pre reset", 9'h0A1, 9'h0A4, 9'h0A1, 16'hFFFF, 16'h0000);
        #3;
        reset_n = 1'b0;
        #1;
        check("async sprdata", {14'd0, sprdata}, 16'd0);
        check("async nsprite", {15'd0, nsprite}, 16'd0);
        check("async attach", {15'd0, attach}, 16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sweep("post reset", 9'h000, 9'h014, 9'h000, 16'h0000, 16'h0000);
        wr(DataA, 16'hC000);
        sweep("post rearm", 9'h000, 9'h014, 9'h000, 16'hC000, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
